// File: rtl/defines.sv
// Shared decode definitions: data/instruction types, RV opcodes, immediate
// formats and the helpers that classify and assemble immediates.
package defines;

  localparam int XLEN_DEFAULT = 32;

  typedef logic [XLEN_DEFAULT-1:0] data_t;
  typedef logic [31:0]             instr_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: t = IMM_I;
      OP_STORE:                           t = IMM_S;
      OP_BRANCH:                          t = IMM_B;
      OP_LUI, OP_AUIPC:                   t = IMM_U;
      OP_JAL:                             t = IMM_J;
      default:                            t = IMM_NONE;
    endcase
    return t;
  endfunction

  // 32-bit immediate, already sign-extended from instr[31]; callers widen it.
  function automatic logic [31:0] imm32_of(input instr_t i, input imm_type_e t);
    logic [31:0] v;
    case (t)
      IMM_I:   v = {{20{i[31]}}, i[31:20]};
      IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   v = {i[31:12], 12'b0};
      IMM_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file with hard-wired x0, async clear and an
// optional same-cycle write-to-read bypass.
module regfile_bypass #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [RW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_live;

  assign wr_live = wen && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (BYPASS != 0 && wr_live && waddr == raddr1) rdata1 = wdata;
    if (BYPASS != 0 && wr_live && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage owning the ID/EX register: operand read, immediate and branch
// target generation, load-use stall, flush and held-operand refresh.
module decode_stage
  import defines::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  // Handshake: a transfer happens on an edge where valid && ready; valid must
  // not depend on ready, and the offered payload is sampled only on transfer.
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            wb_wren,
  input  logic [RW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [RW-1:0]   out_rs1_addr,
  output logic [RW-1:0]   out_rs2_addr,
  output logic [RW-1:0]   out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7_5,
  output logic            out_is_load
);

  logic [6:0]      opcode;
  logic [RW-1:0]   rs1_idx;
  logic [RW-1:0]   rs2_idx;
  logic [RW-1:0]   rd_idx;
  imm_type_e       imm_type;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            hazard;
  logic            accept;
  logic            wb_live;

  assign opcode   = in_instr[6:0];
  assign rs1_idx  = RW'(in_instr[19:15]);
  assign rs2_idx  = RW'(in_instr[24:20]);
  assign imm_type = imm_type_of(opcode);
  assign imm32    = imm32_of(in_instr, imm_type);
  assign imm      = XLEN'($signed(imm32));
  assign target   = in_pc + imm;
  assign rd_idx   = (imm_type == IMM_S || imm_type == IMM_B) ? '0 : RW'(in_instr[11:7]);
  assign wb_live  = wb_wren && (wb_addr != '0);

  regfile_bypass #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wen    (wb_wren),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1_idx),
    .rdata1 (rs1_val),
    .raddr2 (rs2_idx),
    .rdata2 (rs2_val)
  );

  // Both rs fields are compared whatever the format; a false stall is harmless.
  assign hazard = out_valid && out_is_load && (out_rd != '0) &&
                  ((out_rd == rs1_idx) || (out_rd == rs2_idx));

  assign in_ready = !rst && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_imm      <= '0;
      out_target   <= '0;
      out_rs1_addr <= '0;
      out_rs2_addr <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7_5 <= 1'b0;
      out_is_load  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1      <= rs1_val;
      out_rs2      <= rs2_val;
      out_imm      <= imm;
      out_target   <= target;
      out_rs1_addr <= rs1_idx;
      out_rs2_addr <= rs2_idx;
      out_rd       <= rd_idx;
      out_opcode   <= opcode;
      out_funct3   <= in_instr[14:12];
      out_funct7_5 <= in_instr[30];
      out_is_load  <= (opcode == OP_LOAD);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid && wb_live) begin
      // A stalled slot tracks its producers retiring so EX sees fresh operands.
      if (wb_addr == out_rs1_addr) out_rs1 <= wb_data;
      if (wb_addr == out_rs2_addr) out_rs2 <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit bypassing instance, a 32-bit
// non-bypassing instance and a 64-bit instance driven by the same stimulus.
module tb_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, wb_wren, flush, out_ready;
  logic [63:0] pc, wb_data;
  logic [31:0] instr;
  logic [4:0]  wb_addr;

  logic        a_in_ready, a_out_valid, a_funct7_5, a_is_load;
  logic [31:0] a_pc, a_rs1, a_rs2, a_imm, a_target;
  logic [4:0]  a_rs1_addr, a_rs2_addr, a_rd;
  logic [6:0]  a_opcode;
  logic [2:0]  a_funct3;

  logic        n_in_ready, n_out_valid, n_funct7_5, n_is_load;
  logic [31:0] n_pc, n_rs1, n_rs2, n_imm, n_target;
  logic [4:0]  n_rs1_addr, n_rs2_addr, n_rd;
  logic [6:0]  n_opcode;
  logic [2:0]  n_funct3;

  logic        w_in_ready, w_out_valid, w_funct7_5, w_is_load;
  logic [63:0] w_pc, w_rs1, w_rs2, w_imm, w_target;
  logic [4:0]  w_rs1_addr, w_rs2_addr, w_rd;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;

  decode_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(pc[31:0]), .in_instr(instr), .wb_wren(wb_wren), .wb_addr(wb_addr),
    .wb_data(wb_data[31:0]), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_imm(a_imm), .out_target(a_target), .out_rs1_addr(a_rs1_addr),
    .out_rs2_addr(a_rs2_addr), .out_rd(a_rd), .out_opcode(a_opcode),
    .out_funct3(a_funct3), .out_funct7_5(a_funct7_5), .out_is_load(a_is_load)
  );

  decode_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_pc(pc[31:0]), .in_instr(instr), .wb_wren(wb_wren), .wb_addr(wb_addr),
    .wb_data(wb_data[31:0]), .flush(flush), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_pc(n_pc), .out_rs1(n_rs1), .out_rs2(n_rs2),
    .out_imm(n_imm), .out_target(n_target), .out_rs1_addr(n_rs1_addr),
    .out_rs2_addr(n_rs2_addr), .out_rd(n_rd), .out_opcode(n_opcode),
    .out_funct3(n_funct3), .out_funct7_5(n_funct7_5), .out_is_load(n_is_load)
  );

  decode_stage #(.XLEN(64), .NUM_REGS(32), .BYPASS(1)) u_wide (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_pc(pc), .in_instr(instr), .wb_wren(wb_wren), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_pc(w_pc), .out_rs1(w_rs1), .out_rs2(w_rs2),
    .out_imm(w_imm), .out_target(w_target), .out_rs1_addr(w_rs1_addr),
    .out_rs2_addr(w_rs2_addr), .out_rd(w_rd), .out_opcode(w_opcode),
    .out_funct3(w_funct3), .out_funct7_5(w_funct7_5), .out_is_load(w_is_load)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        ld;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'hFFF00293, 64'h0,        32'hFFFFFFFF, 32'hFFFFFFFF,
                64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd5,  7'h13, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{32'h0050A423, 64'h4,        32'h00000008, 32'h0000000C,
                64'h8,                64'hC,                5'd0,  7'h23, 3'd2, 1'b0, 1'b0};
    vecs[2] = '{32'hFE000CE3, 64'h100,      32'hFFFFFFF8, 32'h000000F8,
                64'hFFFFFFFFFFFFFFF8, 64'hF8,               5'd0,  7'h63, 3'd0, 1'b1, 1'b0};
    vecs[3] = '{32'h800003B7, 64'h1000,     32'h80000000, 32'h80001000,
                64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 5'd7,  7'h37, 3'd0, 1'b0, 1'b0};
    vecs[4] = '{32'h010000EF, 64'hFFFFFFF8, 32'h00000010, 32'h00000008,
                64'h10,               64'h100000008,        5'd1,  7'h6F, 3'd0, 1'b0, 1'b0};
    vecs[5] = '{32'h12345197, 64'h300,      32'h12345000, 32'h12345300,
                64'h12345000,         64'h12345300,         5'd3,  7'h17, 3'd5, 1'b0, 1'b0};
    vecs[6] = '{32'h0040A103, 64'h400,      32'h00000004, 32'h00000404,
                64'h4,                64'h404,              5'd2,  7'h03, 3'd2, 1'b0, 1'b1};
    vecs[7] = '{32'hFFFFFFFF, 64'hFFFFFFFC, 32'h00000000, 32'hFFFFFFFC,
                64'h0,                64'hFFFFFFFC,         5'd31, 7'h7F, 3'd7, 1'b1, 1'b0};

    // Reset held for three cycles with an instruction on offer
    rst = 1'b1; in_valid = 1'b1; instr = 32'h005280B3; pc = 64'h0;
    wb_wren = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("reset_in_ready[%0d]", c), a_in_ready, 1'b0);
      check($sformatf("reset_out_valid[%0d]", c), a_out_valid, 1'b0);
    end
    check("reset_out_pc", a_pc, 32'h0);
    check("reset_out_target", a_target, 32'h0);
    rst = 1'b0;
    #1 check("post_reset_in_ready", a_in_ready, 1'b1);
    tick();
    check("x5_valid", a_out_valid, 1'b1);
    check("x5_rs1", a_rs1, 32'h0);
    check("x5_rs2", a_rs2, 32'h0);
    check("x5_rs1_addr", a_rs1_addr, 5'd5);

    // Same-cycle write-back of x3 while decoding add x1,x3,x0
    instr = 32'h000180B3; pc = 64'h10;
    wb_wren = 1'b1; wb_addr = 5'd3; wb_data = 64'h00000000DEADBEEF;
    tick();
    wb_wren = 1'b0;
    check("bypass_rs1", a_rs1, 32'hDEADBEEF);
    check("nobypass_rs1", n_rs1, 32'h0);
    check("bypass_rs1_w64", w_rs1, 64'hDEADBEEF);

    // Back-to-back immediate/target vectors at full throughput
    for (int i = 0; i < 8; i++) begin
      instr = vecs[i].instr; pc = vecs[i].pc; in_valid = 1'b1; out_ready = 1'b1;
      #1 check($sformatf("vec_in_ready[%0d]", i), a_in_ready, 1'b1);
      tick();
      check($sformatf("vec_valid[%0d]", i), a_out_valid, 1'b1);
      check($sformatf("vec_pc[%0d]", i), a_pc, vecs[i].pc[31:0]);
      check($sformatf("vec_imm[%0d]", i), a_imm, vecs[i].imm);
      check($sformatf("vec_target[%0d]", i), a_target, vecs[i].tgt);
      check($sformatf("vec_rd[%0d]", i), a_rd, vecs[i].rd);
      check($sformatf("vec_opcode[%0d]", i), a_opcode, vecs[i].op);
      check($sformatf("vec_funct3[%0d]", i), a_funct3, vecs[i].f3);
      check($sformatf("vec_funct7_5[%0d]", i), a_funct7_5, vecs[i].f7);
      check($sformatf("vec_is_load[%0d]", i), a_is_load, vecs[i].ld);
      check($sformatf("vec_imm64[%0d]", i), w_imm, vecs[i].imm64);
      check($sformatf("vec_target64[%0d]", i), w_target, vecs[i].tgt64);
    end

    // Load-use: lw x2,4(x1) then addi x4,x2,1
    instr = 32'h0040A103; pc = 64'h500;
    tick();
    check("lu_valid_0", a_out_valid, 1'b1);
    instr = 32'h00110213; pc = 64'h504;
    #1 check("lu_stall", a_in_ready, 1'b0);
    tick();
    check("lu_valid_1", a_out_valid, 1'b0);
    check("lu_ready_after_bubble", a_in_ready, 1'b1);
    tick();
    check("lu_valid_2", a_out_valid, 1'b1);
    check("lu_imm", a_imm, 32'h1);
    check("lu_rd", a_rd, 5'd4);
    check("lu_pc", a_pc, 32'h504);

    // Held-operand refresh on a stalled add x9,x6,x6
    in_valid = 1'b0; wb_wren = 1'b1; wb_addr = 5'd6; wb_data = 64'h1;
    tick();
    wb_wren = 1'b0; in_valid = 1'b1; instr = 32'h006304B3; pc = 64'h600;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("hold_rs1_init", a_rs1, 32'h1);
    tick();
    check("hold_stable_rs1", a_rs1, 32'h1);
    check("hold_stable_valid", a_out_valid, 1'b1);
    wb_wren = 1'b1; wb_addr = 5'd6; wb_data = 64'h55;
    tick();
    wb_wren = 1'b0;
    check("refresh_rs1", a_rs1, 32'h55);
    check("refresh_rs2", a_rs2, 32'h55);
    check("refresh_nobypass_rs1", n_rs1, 32'h55);
    check("refresh_rd", a_rd, 5'd9);
    check("refresh_pc", a_pc, 32'h600);
    check("refresh_imm", a_imm, 32'h0);
    check("refresh_valid", a_out_valid, 1'b1);

    // Flush over a held slot with a new instruction offered
    flush = 1'b1; in_valid = 1'b1; instr = 32'hFFF00293; pc = 64'h700;
    #1 check("flush_held_in_ready", a_in_ready, 1'b0);
    tick();
    check("flush_valid", a_out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("flush_quiet[%0d]", c), a_out_valid, 1'b0);
    end

    // Flush and accept in the same cycle: flush wins
    flush = 1'b1; in_valid = 1'b1; instr = 32'h000180B3; pc = 64'h800;
    #1 check("flush_accept_in_ready", a_in_ready, 1'b1);
    tick();
    check("flush_accept_valid", a_out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_accept_quiet", a_out_valid, 1'b0);

    // Writes to x0 are ignored, including on the bypass path
    wb_wren = 1'b1; wb_addr = 5'd0; wb_data = 64'hFF;
    tick();
    in_valid = 1'b1; instr = 32'h000000B3; pc = 64'h900;
    tick();
    wb_wren = 1'b0; in_valid = 1'b0;
    check("x0_rs1", a_rs1, 32'h0);
    check("x0_rs2", a_rs2, 32'h0);
    check("x0_nobypass_rs1", n_rs1, 32'h0);

    // Reset asserted while a slot is stalled
    in_valid = 1'b1; instr = 32'h000180B3; pc = 64'hA00; out_ready = 1'b1;
    tick();
    check("pre_rst_rs1", a_rs1, 32'hDEADBEEF);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", a_out_valid, 1'b0);
    check("midrst_in_ready", a_in_ready, 1'b0);
    check("midrst_rs1", a_rs1, 32'h0);
    tick();
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("post_midrst_valid", a_out_valid, 1'b1);
    check("post_midrst_x3", a_rs1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
